// File: rtl/vt512_pkg.sv
// Shared types and constants for the pixel unpacker.
package vt512_pkg;

  localparam int unsigned PIXEL_WIDTH     = 8;
  localparam int unsigned PIXELS_PER_WORD = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and a synchronous flush.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == DepthCnt);
  assign empty_o   = (count_q == '0);
  assign wr_fire   = wr_en_i && !full_o && !flush_i;
  assign rd_fire   = rd_en_i && !empty_o && !flush_i;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrW'(1);
      if (rd_fire) rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pixel_unpacker.sv
// Unpacks FIFO-buffered packed words into an N x N pixel stream with frame markers.
// Define PIXEL_UNPACKER_STATS_EN to build the completed-frame counter.
module pixel_unpacker #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned PIXEL_WIDTH         = 8,
  parameter int unsigned MAX_IMAGE_SIZE      = 512,
  parameter int unsigned MAX_IMAGE_SIZE_LOG2 = 9,
  parameter int unsigned FIFO_DEPTH          = 4
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           size_valid_i,
  input  logic [MAX_IMAGE_SIZE_LOG2:0]   image_size_i,
  input  logic                           word_valid_i,
  input  logic [DATA_WIDTH-1:0]          word_data_i,
  output logic                           word_ready_o,
  output logic                           pix_valid_o,
  input  logic                           pix_ready_i,
  output logic [PIXEL_WIDTH-1:0]         pix_data_o,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   pix_col_o,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   pix_row_o,
  output logic                           sof_o,
  output logic                           eol_o,
  output logic                           eof_o,
  output logic                           frame_done_o,
  output logic                           overflow_err_o,
  output logic [15:0]                    frame_count_o
);
  import vt512_pkg::*;

  localparam int unsigned SizeW = MAX_IMAGE_SIZE_LOG2 + 1;
  localparam int unsigned Ppw   = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned LaneW = (Ppw > 1) ? $clog2(Ppw) : 1;
  localparam logic [SizeW-1:0] MaxSize  = SizeW'(MAX_IMAGE_SIZE);
  localparam logic [LaneW-1:0] LastLane = LaneW'(Ppw - 1);

  state_e st_q, st_d;
  logic                   size_prev_q;
  logic [SizeW-1:0]       size_q, size_d, n_last;
  logic                   size_rise, size_ok;
  logic                   fifo_wr, fifo_rd, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_rdata;
  logic                   upk_valid_q, upk_valid_d;
  logic [DATA_WIDTH-1:0]  upk_data_q, upk_data_d;
  logic [LaneW-1:0]       upk_lane_q, upk_lane_d;
  logic [SizeW-1:0]       gen_col_q, gen_col_d, gen_row_q, gen_row_d;
  logic                   gen_done_q, gen_done_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [PIXEL_WIDTH-1:0] pix_data_q, pix_data_d;
  logic [SizeW-1:0]       pix_col_q, pix_col_d, pix_row_q, pix_row_d;
  logic                   overflow_q, overflow_d;
  logic                   out_adv, load_pix, upk_empties, pix_xfer;

  assign size_rise = size_valid_i && !size_prev_q;
  assign size_ok   = (image_size_i != '0) && (image_size_i <= MaxSize);
  assign n_last    = size_q - SizeW'(1);
  assign pix_xfer  = pix_valid_q && pix_ready_i;

  assign pix_valid_o    = pix_valid_q;
  assign pix_data_o     = pix_data_q;
  assign pix_col_o      = pix_col_q;
  assign pix_row_o      = pix_row_q;
  assign sof_o          = pix_valid_q && (pix_col_q == '0) && (pix_row_q == '0);
  assign eol_o          = pix_valid_q && (pix_col_q == n_last);
  assign eof_o          = eol_o && (pix_row_q == n_last);
  assign overflow_err_o = overflow_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) st_q <= StIdle;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:   if (size_rise && size_ok) st_d = StStream;
      StStream: if (pix_xfer && eof_o) st_d = StDone;
      StDone:   st_d = StIdle;
      default:  st_d = StIdle;
    endcase
  end

  always_comb begin
    word_ready_o = (st_q == StStream) && !fifo_full;
    frame_done_o = (st_q == StDone);
    fifo_flush   = (st_q == StDone);
  end

  sync_fifo #(
    .Width(DATA_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .flush_i  (fifo_flush),
    .wr_en_i  (fifo_wr),
    .wr_data_i(word_data_i),
    .rd_en_i  (fifo_rd),
    .rd_data_o(fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Once the eof pixel is loaded, leftover lanes of the final word are never used.
  assign out_adv     = !pix_valid_q || pix_ready_i;
  assign load_pix    = (st_q == StStream) && upk_valid_q && out_adv && !gen_done_q;
  assign upk_empties = !upk_valid_q || (load_pix && (upk_lane_q == LastLane));
  assign fifo_rd     = (st_q == StStream) && !fifo_empty && !gen_done_q && upk_empties;
  assign fifo_wr     = word_valid_i && word_ready_o;

  always_comb begin
    size_d      = (st_q == StIdle && size_rise && size_ok) ? image_size_i : size_q;
    upk_valid_d = upk_valid_q;
    upk_data_d  = upk_data_q;
    upk_lane_d  = upk_lane_q;
    gen_col_d   = gen_col_q;
    gen_row_d   = gen_row_q;
    gen_done_d  = gen_done_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_col_d   = pix_col_q;
    pix_row_d   = pix_row_q;
    overflow_d  = overflow_q | ((st_q == StStream) && word_valid_i && !word_ready_o);
    if (load_pix) begin
      upk_data_d = upk_data_q >> PIXEL_WIDTH;
      upk_lane_d = upk_lane_q + LaneW'(1);
      if (upk_lane_q == LastLane) upk_valid_d = 1'b0;
      if (gen_col_q == n_last) begin
        gen_col_d = '0;
        if (gen_row_q == n_last) gen_done_d = 1'b1;
        else                     gen_row_d  = gen_row_q + SizeW'(1);
      end else begin
        gen_col_d = gen_col_q + SizeW'(1);
      end
    end
    if (fifo_rd) begin
      upk_valid_d = 1'b1;
      upk_data_d  = fifo_rdata;
      upk_lane_d  = '0;
    end
    if (out_adv) begin
      pix_valid_d = load_pix;
      if (load_pix) begin
        pix_data_d = upk_data_q[PIXEL_WIDTH-1:0];
        pix_col_d  = gen_col_q;
        pix_row_d  = gen_row_q;
      end
    end
    if (st_q != StStream) begin
      upk_valid_d = 1'b0;
      upk_lane_d  = '0;
      gen_col_d   = '0;
      gen_row_d   = '0;
      gen_done_d  = 1'b0;
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      size_prev_q <= 1'b0;
      size_q      <= '0;
      upk_valid_q <= 1'b0;
      upk_data_q  <= '0;
      upk_lane_q  <= '0;
      gen_col_q   <= '0;
      gen_row_q   <= '0;
      gen_done_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      size_prev_q <= size_valid_i;
      size_q      <= size_d;
      upk_valid_q <= upk_valid_d;
      upk_data_q  <= upk_data_d;
      upk_lane_q  <= upk_lane_d;
      gen_col_q   <= gen_col_d;
      gen_row_q   <= gen_row_d;
      gen_done_q  <= gen_done_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef PIXEL_UNPACKER_STATS_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)              frame_cnt_q <= '0;
    else if (st_q == StDone)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_count_o = frame_cnt_q;
`else
  assign frame_count_o = '0;
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed self-checking bench for pixel_unpacker (default parameters).
module tb_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        size_valid = 1'b0;
  logic [9:0]  image_size = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        pix_ready = 1'b0;
  logic        word_ready, pix_valid, sof, eol, eof, frame_done, overflow;
  logic [7:0]  pix_data;
  logic [9:0]  pix_col, pix_row;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] col;
    logic [9:0] row;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  pix_t got_q[$];
  int   done_cnt = 0;

  pixel_unpacker dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .size_valid_i  (size_valid),
    .image_size_i  (image_size),
    .word_valid_i  (word_valid),
    .word_data_i   (word_data),
    .word_ready_o  (word_ready),
    .pix_valid_o   (pix_valid),
    .pix_ready_i   (pix_ready),
    .pix_data_o    (pix_data),
    .pix_col_o     (pix_col),
    .pix_row_o     (pix_row),
    .sof_o         (sof),
    .eol_o         (eol),
    .eof_o         (eof),
    .frame_done_o  (frame_done),
    .overflow_err_o(overflow),
    .frame_count_o (frame_count)
  );

  always #5 clk = ~clk;

  // Record transfers and done pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pix_t p;
    if (pix_valid && pix_ready) begin
      p.data = pix_data; p.col = pix_col; p.row = pix_row;
      p.sof = sof; p.eol = eol; p.eof = eof;
      got_q.push_back(p);
    end
    if (frame_done) done_cnt++;
  end

  function automatic pix_t exp_pix(input int idx, input int n);
    pix_t p;
    int c, r;
    c = idx % n;
    r = idx / n;
    p.data = 8'(idx); p.col = 10'(c); p.row = 10'(r);
    p.sof = (idx == 0); p.eol = (c == n - 1); p.eof = (idx == n * n - 1);
    return p;
  endfunction

  function automatic logic [31:0] word_of(input int w);
    return {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
  endfunction

  function automatic pix_t cur_pix();
    pix_t p;
    p.data = pix_data; p.col = pix_col; p.row = pix_row;
    p.sof = sof; p.eol = eol; p.eof = eof;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    size_valid = 1'b1;
    image_size = 10'(n);
    tick();
    size_valid = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    while (!word_ready && n < 100) begin tick(); n++; end
    if (!word_ready) begin
      checks++; failures++;
      $display("FAIL send_word_timeout: word_ready_o=%0b required 1", word_ready);
    end
    word_valid = 1'b1;
    word_data  = d;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin tick(); n++; end
    if (done_cnt < target) begin
      checks++; failures++;
      $display("FAIL frame_done_timeout: done=%0d required %0d", done_cnt, target);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({word_ready, pix_valid, sof, eol, eof, frame_done, overflow} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000000",
               {word_ready, pix_valid, sof, eol, eof, frame_done, overflow});
    end
    checks++;
    if ({pix_data, pix_col, pix_row, frame_count} !== 44'd0) begin
      failures++;
      $display("FAIL reset_values: got %h required 0", {pix_data, pix_col, pix_row, frame_count});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (word_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_word_ready: got %0b required 0", word_ready);
    end
  endtask

  task automatic test_n4();
    int base = got_q.size();
    int dbase = done_cnt;
    pix_ready = 1'b1;
    start_frame(4);
    checks++;
    if (word_ready !== 1'b1) begin
      failures++;
      $display("FAIL stream_word_ready: got %0b required 1", word_ready);
    end
    word_valid = 1'b1;
    word_data  = word_of(0);
    tick();
    word_valid = 1'b0;
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_k: pix_valid_o=%0b required 0", pix_valid);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_k1: pix_valid_o=%0b required 0", pix_valid);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_k2: pix_valid_o=%0b required 1", pix_valid);
    end
    for (int w = 1; w < 4; w++) send_word(word_of(w));
    wait_frames(dbase + 1);
    repeat (3) tick();
    checks++;
    if (got_q.size() - base != 16) begin
      failures++;
      $display("FAIL n4_count: got %0d pixels required 16", got_q.size() - base);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (base + i >= got_q.size()) begin
        failures++;
        $display("FAIL n4_pix%0d: got none required %h", i, exp_pix(i, 4));
      end else if (got_q[base + i] !== exp_pix(i, 4)) begin
        failures++;
        $display("FAIL n4_pix%0d: got %h required %h", i, got_q[base + i], exp_pix(i, 4));
      end
    end
    checks++;
    if (done_cnt - dbase != 1) begin
      failures++;
      $display("FAIL n4_done_pulses: got %0d required 1", done_cnt - dbase);
    end
    checks++;
    if ({word_ready, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL n4_after: ready/overflow=%b required 00", {word_ready, overflow});
    end
  endtask

  task automatic test_n3();
    int base = got_q.size();
    int dbase = done_cnt;
    pix_ready = 1'b1;
    start_frame(3);
    send_word(32'h0302_0100);
    send_word(32'h0706_0504);
    send_word(32'hDDCC_BB08);
    wait_frames(dbase + 1);
    repeat (3) tick();
    checks++;
    if (got_q.size() - base != 9) begin
      failures++;
      $display("FAIL n3_count: got %0d pixels required 9", got_q.size() - base);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (base + i >= got_q.size()) begin
        failures++;
        $display("FAIL n3_pix%0d: got none required %h", i, exp_pix(i, 3));
      end else if (got_q[base + i] !== exp_pix(i, 3)) begin
        failures++;
        $display("FAIL n3_pix%0d: got %h required %h", i, got_q[base + i], exp_pix(i, 3));
      end
    end
  endtask

  task automatic test_illegal_size();
    int base = got_q.size();
    start_frame(0);
    repeat (2) tick();
    checks++;
    if (word_ready !== 1'b0) begin
      failures++;
      $display("FAIL size0_ready: got %0b required 0", word_ready);
    end
    start_frame(513);
    repeat (2) tick();
    checks++;
    if (word_ready !== 1'b0) begin
      failures++;
      $display("FAIL size513_ready: got %0b required 0", word_ready);
    end
    size_valid = 1'b1;
    image_size = 10'd600;
    tick();
    image_size = 10'd4;
    repeat (3) tick();
    checks++;
    if (word_ready !== 1'b0) begin
      failures++;
      $display("FAIL held_size_ready: got %0b required 0", word_ready);
    end
    size_valid = 1'b0;
    tick();
    word_valid = 1'b1;
    word_data  = 32'h1234_5678;
    tick();
    word_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if ({overflow, pix_valid} !== 2'b00 || got_q.size() != base) begin
      failures++;
      $display("FAIL idle_word_drop: overflow/valid=%b pixels=%0d required 00 and 0",
               {overflow, pix_valid}, got_q.size() - base);
    end
  endtask

  task automatic test_stall_overflow();
    int base = got_q.size();
    int dbase = done_cnt;
    int acc = 0;
    int nxt = 1;
    int changes = 0;
    bit have = 0;
    pix_t held;
    pix_ready = 1'b1;
    start_frame(8);
    send_word(word_of(0));
    repeat (6) tick();
    checks++;
    if (got_q.size() - base != 4) begin
      failures++;
      $display("FAIL stall_pre: got %0d pixels required 4", got_q.size() - base);
    end
    pix_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (word_ready) begin
        word_valid = 1'b1;
        word_data  = word_of(nxt);
        nxt++;
        acc++;
      end else begin
        word_valid = 1'b0;
      end
      tick();
      if (pix_valid) begin
        if (have && cur_pix() !== held) changes++;
        if (!have) begin held = cur_pix(); have = 1; end
      end
    end
    word_valid = 1'b0;
    checks++;
    if (acc != 5) begin
      failures++;
      $display("FAIL stall_accepted: got %0d words required 5", acc);
    end
    checks++;
    if ({word_ready, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL stall_ready: ready/overflow=%b required 00", {word_ready, overflow});
    end
    checks++;
    if (!have || changes != 0 || held !== exp_pix(4, 8)) begin
      failures++;
      $display("FAIL stall_stable: held=%h changes=%0d required %h and 0",
               held, changes, exp_pix(4, 8));
    end
    checks++;
    if (got_q.size() - base != 4) begin
      failures++;
      $display("FAIL stall_no_xfer: got %0d pixels required 4", got_q.size() - base);
    end
    word_valid = 1'b1;
    word_data  = 32'hEEEE_EEEE;
    tick();
    word_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got %0b required 1", overflow);
    end
    pix_ready = 1'b1;
    for (int w = nxt; w < 16; w++) send_word(word_of(w));
    wait_frames(dbase + 1);
    repeat (3) tick();
    checks++;
    if (got_q.size() - base != 64) begin
      failures++;
      $display("FAIL n8_count: got %0d pixels required 64", got_q.size() - base);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (base + i >= got_q.size()) begin
        failures++;
        $display("FAIL n8_pix%0d: got none required %h", i, exp_pix(i, 8));
      end else if (got_q[base + i] !== exp_pix(i, 8)) begin
        failures++;
        $display("FAIL n8_pix%0d: got %h required %h", i, got_q[base + i], exp_pix(i, 8));
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got %0b required 1", overflow);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: got %0b required 0", overflow);
    end
  endtask

  task automatic test_reset_midframe();
    int base = got_q.size();
    int dbase;
    int n = 0;
    pix_ready = 1'b1;
    start_frame(4);
    send_word(word_of(0));
    send_word(word_of(1));
    while (got_q.size() - base < 5 && n < 50) begin tick(); n++; end
    checks++;
    if (got_q.size() - base < 5) begin
      failures++;
      $display("FAIL midframe_reach: got %0d pixels required 5", got_q.size() - base);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({word_ready, pix_valid, sof, eol, eof, frame_done, overflow} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_flags: got %b required 0000000",
               {word_ready, pix_valid, sof, eol, eof, frame_done, overflow});
    end
    checks++;
    if ({pix_data, pix_col, pix_row, frame_count} !== 44'd0) begin
      failures++;
      $display("FAIL midreset_values: got %h required 0", {pix_data, pix_col, pix_row, frame_count});
    end
    tick();
    rst = 1'b0;
    tick();
    base  = got_q.size();
    dbase = done_cnt;
    start_frame(4);
    for (int w = 0; w < 4; w++) send_word(word_of(w));
    wait_frames(dbase + 1);
    checks++;
    if (got_q.size() - base != 16 || got_q[base] !== exp_pix(0, 4)) begin
      failures++;
      $display("FAIL restart_frame: pixels=%0d first=%h required 16 and %h",
               got_q.size() - base, (got_q.size() > base) ? got_q[base] : '0, exp_pix(0, 4));
    end
    checks++;
    if (got_q.size() - base >= 16 && got_q[base + 15] !== exp_pix(15, 4)) begin
      failures++;
      $display("FAIL restart_last: got %h required %h", got_q[base + 15], exp_pix(15, 4));
    end
  endtask

  task automatic test_back_to_back();
    int dbase;
    logic [15:0] exp_cnt;
`ifdef PIXEL_UNPACKER_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    dbase = done_cnt;
    pix_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int base = got_q.size();
      start_frame(2);
      send_word(word_of(0));
      wait_frames(dbase + f + 1);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (base + i >= got_q.size()) begin
          failures++;
          $display("FAIL b2b_f%0d_pix%0d: got none required %h", f, i, exp_pix(i, 2));
        end else if (got_q[base + i] !== exp_pix(i, 2)) begin
          failures++;
          $display("FAIL b2b_f%0d_pix%0d: got %h required %h", f, i, got_q[base + i],
                   exp_pix(i, 2));
        end
      end
    end
    tick();
    checks++;
    if (frame_count !== exp_cnt) begin
      failures++;
      $display("FAIL frame_count: got %0d required %0d", frame_count, exp_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_n4();
    test_n3();
    test_illegal_size();
    test_stall_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
